// File: rtl/div_nr_if.sv
// Request/response bundle for the div_nr divider.
// The slave view is the divider itself and the master view is the requester/consumer.
interface div_nr_if #(
  parameter int DW = 8
) ();
  logic          valid_i;
  logic          ready_o;
  logic          tc_mode_i;
  logic [DW-1:0] a_i;
  logic [DW-1:0] b_i;
  logic          valid_o;
  logic          ready_i;
  logic [DW-1:0] q_o;
  logic [DW-1:0] r_o;
  logic          dz_o;
  logic          ov_o;

  modport slave (
    input  valid_i, tc_mode_i, a_i, b_i, ready_i,
    output ready_o, valid_o, q_o, r_o, dz_o, ov_o
  );

  modport master (
    output valid_i, tc_mode_i, a_i, b_i, ready_i,
    input  ready_o, valid_o, q_o, r_o, dz_o, ov_o
  );
endinterface

// File: rtl/div_nr.sv
// Iterative radix-2 non-restoring divider, one quotient bit per cycle, signed or unsigned.
// Optional macro MATH_DIV_EARLY_EXIT_EN skips the iterations for dz, ov and |a| < |b|.
module div_nr #(
  parameter int DW = 8
) (
  input  logic     clk_i,
  input  logic     rst_i,
  div_nr_if.slave  bus
);
  localparam int CW = $clog2(DW);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_POST, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          tc_q, tc_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] ub_q, ub_d;
  logic [DW-1:0] dq_q, dq_d;
  logic [DW:0]   pr_q, pr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sq_q, sq_d;
  logic          sr_q, sr_d;
  logic          dz_q, dz_d;
  logic          ov_q, ov_d;
  logic [DW-1:0] q_q, q_d;
  logic [DW-1:0] r_q, r_d;
  logic          dzo_q, dzo_d;
  logic          ovo_q, ovo_d;
`ifdef MATH_DIV_EARLY_EXIT_EN
  logic          lt_q, lt_d;
`endif

  logic [DW-1:0] abs_a, abs_b, rem_mag;
  logic [DW:0]   pr_shift, pr_step, rem_fix;
  logic          dz_now, ov_now;

  assign abs_a  = (tc_q && a_q[DW-1]) ? -a_q : a_q;
  assign abs_b  = (tc_q && b_q[DW-1]) ? -b_q : b_q;
  assign dz_now = (b_q == '0);
  assign ov_now = tc_q && (a_q == {1'b1, {(DW-1){1'b0}}}) && (b_q == '1);

  // dq_q starts as |a| and is shifted left: its MSB feeds the remainder,
  // the freed LSB collects the new quotient bit.
  assign pr_shift = {pr_q[DW-1:0], dq_q[DW-1]};
  assign pr_step  = pr_q[DW] ? (pr_shift + {1'b0, ub_q}) : (pr_shift - {1'b0, ub_q});
  assign rem_fix  = pr_q[DW] ? (pr_q + {1'b0, ub_q}) : pr_q;
  assign rem_mag  = rem_fix[DW-1:0];

  always_comb begin
    state_d = state_q;
    tc_d    = tc_q;
    a_d     = a_q;
    b_d     = b_q;
    ub_d    = ub_q;
    dq_d    = dq_q;
    pr_d    = pr_q;
    cnt_d   = cnt_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    q_d     = q_q;
    r_d     = r_q;
    dzo_d   = dzo_q;
    ovo_d   = ovo_q;
`ifdef MATH_DIV_EARLY_EXIT_EN
    lt_d    = lt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.valid_i) begin
          tc_d    = bus.tc_mode_i;
          a_d     = bus.a_i;
          b_d     = bus.b_i;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        ub_d    = abs_b;
        dq_d    = abs_a;
        pr_d    = '0;
        cnt_d   = CW'(DW - 1);
        sq_d    = tc_q & (a_q[DW-1] ^ b_q[DW-1]);
        sr_d    = tc_q & a_q[DW-1];
        dz_d    = dz_now;
        ov_d    = ov_now;
        state_d = S_CALC;
`ifdef MATH_DIV_EARLY_EXIT_EN
        lt_d = (abs_a < abs_b);
        if (dz_now || ov_now || (abs_a < abs_b)) begin
          state_d = S_POST;
        end
`endif
      end
      S_CALC: begin
        pr_d = pr_step;
        dq_d = {dq_q[DW-2:0], ~pr_step[DW]};
        if (cnt_q == '0) begin
          state_d = S_POST;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_POST: begin
        if (dz_q) begin
          q_d = '1;
          r_d = a_q;
        end else if (ov_q) begin
          q_d = a_q;
          r_d = '0;
`ifdef MATH_DIV_EARLY_EXIT_EN
        end else if (lt_q) begin
          q_d = '0;
          r_d = a_q;
`endif
        end else begin
          q_d = sq_q ? -dq_q : dq_q;
          r_d = sr_q ? -rem_mag : rem_mag;
        end
        dzo_d   = dz_q;
        ovo_d   = ov_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      tc_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ub_q    <= '0;
      dq_q    <= '0;
      pr_q    <= '0;
      cnt_q   <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dzo_q   <= 1'b0;
      ovo_q   <= 1'b0;
`ifdef MATH_DIV_EARLY_EXIT_EN
      lt_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ub_q    <= ub_d;
      dq_q    <= dq_d;
      pr_q    <= pr_d;
      cnt_q   <= cnt_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dzo_q   <= dzo_d;
      ovo_q   <= ovo_d;
`ifdef MATH_DIV_EARLY_EXIT_EN
      lt_q    <= lt_d;
`endif
    end
  end

  assign bus.ready_o = (state_q == S_IDLE);
  assign bus.valid_o = (state_q == S_DONE);
  assign bus.q_o     = q_q;
  assign bus.r_o     = r_q;
  assign bus.dz_o    = dzo_q;
  assign bus.ov_o    = ovo_q;
endmodule

// File: tb/tb_div_nr.sv
// Self-checking bench for div_nr (DW=8): arithmetic model + scoreboard checked every cycle,
// plus directed transactions with hand-computed literal results.
module tb_div_nr;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  typedef struct {
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic          dz;
    logic          ov;
    int            lat;
  } exp_t;

  exp_t sb[$];

  div_nr_if #(.DW(DW)) bus ();

  div_nr #(.DW(DW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Division from first principles: integer / and % truncate toward zero.
  function automatic exp_t model(input logic tc, input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    int   sa, sb_, qi, ri, ma, mb;
    bit   early;
    e.dz = 1'b0;
    e.ov = 1'b0;
    sa = tc ? int'($signed(a)) : int'(a);
    sb_ = tc ? int'($signed(b)) : int'(b);
    ma = (sa < 0) ? -sa : sa;
    mb = (sb_ < 0) ? -sb_ : sb_;
    if (b == 0) begin
      e.dz = 1'b1;
      e.q  = '1;
      e.r  = a;
    end else if (tc && sa == -(1 << (DW-1)) && sb_ == -1) begin
      e.ov = 1'b1;
      e.q  = a;
      e.r  = '0;
    end else begin
      qi  = sa / sb_;
      ri  = sa % sb_;
      e.q = qi[DW-1:0];
      e.r = ri[DW-1:0];
    end
    early = e.dz || e.ov || (ma < mb);
`ifdef MATH_DIV_EARLY_EXIT_EN
    e.lat = early ? 3 : DW + 3;
`else
    e.lat = early ? DW + 3 : DW + 3;
`endif
    return e;
  endfunction

  // One compare process: every cycle, outputs against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready_o", bus.ready_o, 1);
      chk("rst_valid_o", bus.valid_o, 0);
      chk("rst_q_o", bus.q_o, 0);
      chk("rst_r_o", bus.r_o, 0);
      chk("rst_flags", {bus.dz_o, bus.ov_o}, 0);
      sb.delete();
    end else begin
      chk("ready_o", bus.ready_o, (sb.size() == 0));
      chk("valid_o", bus.valid_o, (sb.size() != 0) && (cyc - acc_cyc >= sb[0].lat));
      if (bus.valid_o && sb.size() != 0) begin
        chk("model_q", bus.q_o, sb[0].q);
        chk("model_r", bus.r_o, sb[0].r);
        chk("model_dz", bus.dz_o, sb[0].dz);
        chk("model_ov", bus.ov_o, sb[0].ov);
      end
      if (bus.valid_o && bus.ready_i && sb.size() != 0) begin
        void'(sb.pop_front());
      end else if (bus.valid_i && bus.ready_o) begin
        sb.push_back(model(bus.tc_mode_i, bus.a_i, bus.b_i));
        acc_cyc = cyc;
      end
    end
  end

  // sel 0: wait for ready_o, sel 1: wait for valid_o; n = negedges waited.
  task automatic wait_neg(input int sel, input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((sel == 0) ? !bus.ready_o : !bus.valid_o) && n < 100);
    if (n >= 100) timeout(name);
  endtask

  task automatic txn(input logic tc, input logic [DW-1:0] a, input logic [DW-1:0] b,
                     input int hold, input logic [DW-1:0] eq, input logic [DW-1:0] er,
                     input logic edz, input logic eov, input int elat);
    int n, lat;
    @(posedge clk); #1;
    bus.valid_i = 1'b1; bus.tc_mode_i = tc; bus.a_i = a; bus.b_i = b; bus.ready_i = 1'b0;
    wait_neg(0, "accept", n);
    @(posedge clk); #1;
    bus.valid_i = 1'b0; bus.a_i = 8'hA5; bus.b_i = 8'h3C; bus.tc_mode_i = ~tc;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.valid_o && lat < 100);
    if (lat >= 100) timeout("result");
    if (elat > 0) chk("latency", lat, elat);
    repeat (hold) @(posedge clk);
    @(posedge clk); #1;
    bus.ready_i = 1'b1;
    @(negedge clk);
    chk("lit_q", bus.q_o, eq);
    chk("lit_r", bus.r_o, er);
    chk("lit_dz", bus.dz_o, edz);
    chk("lit_ov", bus.ov_o, eov);
    @(posedge clk); #1;
    bus.ready_i = 1'b0;
    $display("txn tc=%0d a=%02h b=%02h -> q=%02h r=%02h dz=%0d ov=%0d", tc, a, b, eq, er, edz, eov);
  endtask

  int n, t1, t2;

  initial begin
    bus.valid_i = 1'b0; bus.tc_mode_i = 1'b0; bus.a_i = '0; bus.b_i = '0; bus.ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    txn(1'b0, 8'd200, 8'd7, 0, 8'd28, 8'd4, 1'b0, 1'b0, 11);
    txn(1'b1, 8'hF9, 8'h02, 0, 8'hFD, 8'hFF, 1'b0, 1'b0, 0);
    txn(1'b1, 8'h07, 8'hFE, 0, 8'hFD, 8'h01, 1'b0, 1'b0, 0);
    txn(1'b0, 8'h55, 8'h00, 0, 8'hFF, 8'h55, 1'b1, 1'b0, 0);
    txn(1'b1, 8'h55, 8'h00, 0, 8'hFF, 8'h55, 1'b1, 1'b0, 0);
    txn(1'b1, 8'h80, 8'hFF, 0, 8'h80, 8'h00, 1'b0, 1'b1, 0);
    txn(1'b0, 8'h80, 8'hFF, 0, 8'h00, 8'h80, 1'b0, 1'b0, 0);
    txn(1'b1, 8'h9C, 8'h0B, 5, 8'hF7, 8'hFF, 1'b0, 1'b0, 0);
    txn(1'b0, 8'd3, 8'd200, 0, 8'd0, 8'd3, 1'b0, 1'b0, 0);
    txn(1'b0, 8'hFF, 8'h01, 0, 8'hFF, 8'h00, 1'b0, 1'b0, 0);
    txn(1'b0, 8'hFF, 8'hFF, 0, 8'h01, 8'h00, 1'b0, 1'b0, 0);
    txn(1'b1, 8'h81, 8'h7F, 0, 8'hFF, 8'h00, 1'b0, 1'b0, 0);
    txn(1'b1, 8'hFD, 8'h64, 0, 8'h00, 8'hFD, 1'b0, 1'b0, 0);

    // Back-to-back with valid_i held high and the consumer always ready.
    @(posedge clk); #1;
    bus.ready_i = 1'b1; bus.valid_i = 1'b1; bus.tc_mode_i = 1'b0; bus.a_i = 8'd100; bus.b_i = 8'd9;
    wait_neg(0, "b2b_accept1", n);
    t1 = cyc;
    @(posedge clk); #1;
    bus.tc_mode_i = 1'b1; bus.a_i = 8'hCE; bus.b_i = 8'h07;
    wait_neg(1, "b2b_result1", n);
    chk("b2b_q1", bus.q_o, 8'd11);
    chk("b2b_r1", bus.r_o, 8'd1);
    wait_neg(0, "b2b_accept2", n);
    t2 = cyc;
    chk("b2b_interval", t2 - t1, DW + 4);
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    wait_neg(1, "b2b_result2", n);
    chk("b2b_q2", bus.q_o, 8'hF9);
    chk("b2b_r2", bus.r_o, 8'hFF);
    @(posedge clk); #1;
    bus.ready_i = 1'b0;
    $display("txn b2b 100/9 -> 0b r 01, -50/7 -> f9 r ff");

    // Reset four cycles into an operation aborts it.
    @(posedge clk); #1;
    bus.valid_i = 1'b1; bus.tc_mode_i = 1'b0; bus.a_i = 8'd200; bus.b_i = 8'd7;
    wait_neg(0, "rst_accept", n);
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_ready_o", bus.ready_o, 1);
    chk("abort_valid_o", bus.valid_o, 0);
    chk("abort_q_o", bus.q_o, 0);
    chk("abort_r_o", bus.r_o, 0);
    @(posedge clk); #1 rst = 1'b0;
    $display("txn reset mid-calc -> outputs cleared");
    txn(1'b0, 8'd9, 8'd3, 0, 8'd3, 8'd0, 1'b0, 1'b0, 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
